// File: rtl/div3_pkg.sv
// Shared helpers for schedulers built around the div_by_3 checker.
package div3_pkg;

    // Default width of the divisible-result statistics counter.
    localparam int unsigned CNT_W_DEF = 16;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin successor of ptr, wrapping to 0 after n-1.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/div3_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first requester at or after ptr, with wrap.
module rr_pick
    import div3_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int unsigned best;
    int unsigned best_d;
    int unsigned d;

    // Pick the valid requester with the smallest rotated distance from ptr.
    always_comb begin
        best   = 0;
        best_d = N_REQ;
        d      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            d = (i >= ptr) ? (i - ptr) : (i + N_REQ - ptr);
            if (req[i] && (d < best_d)) begin
                best_d = d;
                best   = i;
            end
        end
        found = en && (best_d < N_REQ);
        idx   = found ? IDX_W'(best) : '0;
        grant = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant[i] = found && (best == i);
        end
    end

endmodule

// File: rtl/div_by_3.sv
// Combinational divisibility-by-3 checker (MSB-first remainder fold).
module div_by_3 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              div3
);

    logic [1:0] rem;

    // Fold bits MSB first: rem' = (2*rem + bit) mod 3.
    always_comb begin
        rem = '0;
        for (int unsigned i = DATA_W; i > 0; i--) begin
            case ({rem, data[i-1]})
                3'b000:  rem = 2'd0;
                3'b001:  rem = 2'd1;
                3'b010:  rem = 2'd2;
                3'b011:  rem = 2'd0;
                3'b100:  rem = 2'd1;
                3'b101:  rem = 2'd2;
                default: rem = 2'd0;
            endcase
        end
        div3 = (rem == 2'd0);
    end

endmodule

// File: rtl/div3_rr_arbiter.sv
// Round-robin front end sharing one div_by_3 checker through a 2-stage pipeline.
module div3_rr_arbiter
    import div3_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDX_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_div,
    output logic                    busy,
    output logic [CNT_W-1:0]        div_cnt
);

    logic              s1_v;
    logic [IDX_W-1:0]  s1_id;
    logic [DATA_W-1:0] s1_data;
    logic              s1_div;
    logic [IDX_W-1:0]  rr_ptr;

    logic              advance1;
    logic              advance2;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  gidx;
    logic              gfound;
    logic [DATA_W-1:0] ops [N_REQ];
    logic [DATA_W-1:0] sel_data;

    // Stage advance conditions and status.
    always_comb begin
        advance2  = !rsp_valid || rsp_ready;
        advance1  = !s1_v || advance2;
        req_ready = grant;
        busy      = s1_v || rsp_valid;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .en    (advance1 && !rst),
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .found (gfound)
    );

    // Unpack operand bus and select the granted operand.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ops[i] = req_data[i*DATA_W +: DATA_W];
        end
        sel_data = ops[gidx];
    end

    div_by_3 #(
        .DATA_W (DATA_W)
    ) u_div (
        .data (s1_data),
        .div3 (s1_div)
    );

    // S1 operand register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_id   <= '0;
            s1_data <= '0;
            rr_ptr  <= '0;
        end else if (advance1) begin
            s1_v <= gfound;
            if (gfound) begin
                s1_id   <= gidx;
                s1_data <= sel_data;
                rr_ptr  <= IDX_W'(rr_next(gidx, N_REQ));
            end
        end
    end

    // S2 response register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_div   <= 1'b0;
        end else if (advance2) begin
            rsp_valid <= s1_v;
            if (s1_v) begin
                rsp_id   <= s1_id;
                rsp_data <= s1_data;
                rsp_div  <= s1_div;
            end
        end
    end

    // Saturating count of accepted divisible responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (rsp_valid && rsp_ready && rsp_div && (div_cnt != '1)) begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_div3_rr_arbiter.sv
// Directed self-checking bench for div3_rr_arbiter (N_REQ=4, DATA_W=8, CNT_W=2).
module tb_div3_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_div;
    logic        busy;
    logic [1:0]  div_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] rq[$];
    int          gq[$];

    div3_rr_arbiter #(
        .DATA_W (8),
        .N_REQ  (4),
        .CNT_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_div   (rsp_div),
        .busy      (busy),
        .div_cnt   (div_cnt)
    );

    always #5 clk = ~clk;

    // Record handshakes mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) rq.push_back({rsp_id, rsp_data, rsp_div});
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) gq.push_back(i);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input int k, input logic [1:0] id,
                           input logic [7:0] d, input logic dv);
        logic [31:0] got;
        got = (k < rq.size()) ? {21'h0, rq[k]} : 32'hFFFF_FFFF;
        check(tag, got, {21'h0, id, d, dv});
    endtask

    task automatic feed0(input logic [7:0] d);
        req_valid = 4'b0001;
        req_data  = {24'h0, d};
        #1 check("t6_rdy", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
    endtask

    logic [3:0] exp_rdy[6];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        tick();
        #1 check("rst_rdy", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(div_cnt), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);
        check("rst_data", 32'(rsp_data), 32'h0);

        // Test 1: single requester back-to-back.
        req_valid = 4'b0001;
        req_data  = {24'h0, 8'd5};
        #1 check("t1_rdy", 32'(req_ready), 32'h1);
        tick();
        check("t1_lat_valid", 32'(rsp_valid), 32'h0);
        check("t1_lat_busy", 32'(busy), 32'h1);
        req_data = {24'h0, 8'd12};
        tick();
        check("t1_r0", {rsp_valid, rsp_id, rsp_data, rsp_div}, {1'b1, 2'd0, 8'd5, 1'b0});
        req_data = {24'h0, 8'd37};
        tick();
        check("t1_r1", {rsp_valid, rsp_id, rsp_data, rsp_div}, {1'b1, 2'd0, 8'd12, 1'b1});
        req_valid = '0;
        tick();
        check("t1_r2", {rsp_valid, rsp_id, rsp_data, rsp_div}, {1'b1, 2'd0, 8'd37, 1'b0});
        tick();
        check("t1_idle_valid", 32'(rsp_valid), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Test 2: all four valid from rr_ptr=0.
        do_reset();
        rq.delete();
        req_valid = 4'b1111;
        req_data  = {8'd7, 8'd45, 8'd33, 8'd29};
        exp_rdy   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        for (int k = 0; k < 5; k++) begin
            #1 check("t2_grant", 32'(req_ready), 32'(exp_rdy[k]));
            if (k == 4) req_valid = '0;
            tick();
        end
        repeat (3) tick();
        check("t2_count", rq.size(), 4);
        chk_rsp("t2_r0", 0, 2'd0, 8'd29, 1'b0);
        chk_rsp("t2_r1", 1, 2'd1, 8'd33, 1'b1);
        chk_rsp("t2_r2", 2, 2'd2, 8'd45, 1'b1);
        chk_rsp("t2_r3", 3, 2'd3, 8'd7, 1'b0);

        // Test 3: fairness between req1 and req3.
        req_valid = 4'b1010;
        req_data  = {8'd1, 8'd0, 8'd2, 8'd0};
        for (int k = 0; k < 6; k++) begin
            #1 check("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Test 4: backpressure with three operands offered.
        do_reset();
        rq.delete();
        gq.delete();
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        req_data  = {8'd0, 8'd12, 8'd11, 8'd10};
        #1 check("t4_g0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0110;
        #1 check("t4_g1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_stall_rdy", 32'(req_ready), 32'h0);
            check("t4_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, 8'd10});
            tick();
        end
        check("t4_accepts", gq.size(), 2);
        rsp_ready = 1'b1;
        #1 check("t4_g2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("t4_count", rq.size(), 3);
        chk_rsp("t4_r0", 0, 2'd0, 8'd10, 1'b0);
        chk_rsp("t4_r1", 1, 2'd1, 8'd11, 1'b0);
        chk_rsp("t4_r2", 2, 2'd2, 8'd12, 1'b1);

        // Test 5: reset with both stages full.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_data  = {24'h0, 8'd3};
        tick();
        tick();
        check("t5_full", {busy, rsp_valid}, 2'b11);
        check("t5_cnt_pre", 32'(div_cnt), 32'h1);
        req_valid = 4'b0011;
        rst = 1'b1;
        #1 check("t5_rst_rdy", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_cnt", 32'(div_cnt), 32'h0);
        check("t5_grant", 32'(req_ready), 32'h1);
        req_valid = '0;

        // Test 6: CNT_W=2 saturation.
        rsp_ready = 1'b1;
        rq.delete();
        feed0(8'd0);
        feed0(8'd3);
        feed0(8'd4);
        repeat (3) tick();
        check("t6_cnt_mid", 32'(div_cnt), 32'h2);
        chk_rsp("t6_r4", 2, 2'd0, 8'd4, 1'b0);
        feed0(8'd6);
        feed0(8'd9);
        feed0(8'd255);
        repeat (3) tick();
        check("t6_cnt_sat", 32'(div_cnt), 32'h3);
        chk_rsp("t6_r255", 5, 2'd0, 8'd255, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
